wb_uart_tx: RTL

Wishbone-slave UART transmitter with a byte FIFO, attached to the third (currently unused) slave port of the user-area Wishbone address mux. The Caravel management core writes bytes over Wishbone, and the block serialises them as 8N1 frames onto a single GPIO pad. It gives firmware a debug/console channel that is independent of the instruction and data RAM paths.

---
 rtl/wb_uart_tx.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone-slave 8N1 UART transmitter with a byte FIFO.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, asynchronous active-high reset
//   wbs_stb_i, wbs_cyc_i,
//   wbs_we_i, wbs_sel_i,
//   wbs_dat_i, wbs_adr_i       Wishbone request (only wbs_adr_i[3:2] decoded)
//   wbs_ack_o, wbs_dat_o       single-cycle ack, read data (0 while ack is low)
//   uart_tx_o                  serial line, idle high
//   irq_o                      TX-done interrupt
//
// Register map (wbs_adr_i[3:2]):
//   0 TXDATA  W: push dat[7:0] (sel[0])       R: 0
//   1 STATUS  R: [15:8] level, [3] overflow, [2] busy, [1] empty, [0] full
//             W: 1 to bit3 (sel[0]) clears overflow
//   2 BAUDDIV R/W [15:0], bit period = BAUDDIV+1 clocks
//   3 CTRL    bit0 irq_en
//
// Build option: define UART_TX_IRQ_EN to enable irq_o and the CTRL register;
// otherwise irq_o is 0 and CTRL reads 0.
module wb_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        uart_tx_o,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Wishbone front end
  logic        r_ack;
  logic [31:0] r_dat;
  logic        w_req, w_wr, w_rd;
  logic [1:0]  w_adr;
  logic [31:0] w_rdata;

  // FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic [LW-1:0] w_level;
  logic          w_full, w_empty, w_push, w_push_ok, w_pop;
  logic          r_ovf;

  // Config
  logic [15:0] r_baud;
  logic        w_irq_en;

  // Transmitter
  state_e      r_state, w_state_d;
  logic [15:0] r_cnt, w_cnt_d, r_div, w_div_d;
  logic [2:0]  r_bit, w_bit_d;
  logic [7:0]  r_shift, w_shift_d;
  logic        w_cnt_end, w_busy;

  logic w_unused_ok;
  assign w_unused_ok = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  // A request is taken only while ack is low, which forces the idle cycle after each ack.
  assign w_req = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_wr  = w_req & wbs_we_i;
  assign w_rd  = w_req & ~wbs_we_i;
  assign w_adr = wbs_adr_i[3:2];

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_level = r_wptr - r_rptr;
  assign w_busy  = (r_state != StIdle);

  assign w_push    = w_wr && (w_adr == 2'd0) && wbs_sel_i[0];
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_comb begin
    w_rdata = '0;
    case (w_adr)
      2'd1:    w_rdata = {16'd0, {(8 - LW){1'b0}}, w_level, 4'd0, r_ovf, w_busy, w_empty, w_full};
      2'd2:    w_rdata = {16'd0, r_baud};
      2'd3:    w_rdata = {31'd0, w_irq_en};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'd0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

  always_ff @(posedge wb_clk_i) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= wbs_dat_i[7:0];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_baud <= DEFAULT_DIV;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)     r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
      if (w_push && !w_push_ok) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_adr == 2'd1) && wbs_sel_i[0] && wbs_dat_i[3]) begin
        r_ovf <= 1'b0;
      end
      if (w_wr && (w_adr == 2'd2)) begin
        if (wbs_sel_i[0]) r_baud[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) r_baud[15:8] <= wbs_dat_i[15:8];
      end
    end
  end

  // Transmitter: every state lasts r_div+1 clocks; the divisor is sampled at frame start.
  assign w_cnt_end = (r_cnt == r_div);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_div_d   = r_div;
    w_pop     = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_state_d = StStart;
          w_pop     = 1'b1;
          w_shift_d = r_mem[r_rptr[AW-1:0]];
          w_div_d   = r_baud;
          w_cnt_d   = '0;
        end
      end
      StStart: begin
        if (w_cnt_end) begin
          w_state_d = StData;
          w_cnt_d   = '0;
          w_bit_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StData: begin
        if (w_cnt_end) begin
          w_cnt_d   = '0;
          w_shift_d = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_d = StStop;
          else               w_bit_d   = r_bit + 3'd1;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StStop: begin
        if (w_cnt_end) begin
          w_cnt_d = '0;
          if (!w_empty) begin
            w_state_d = StStart;
            w_pop     = 1'b1;
            w_shift_d = r_mem[r_rptr[AW-1:0]];
            w_div_d   = r_baud;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_div   <= DEFAULT_DIV;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_div   <= w_div_d;
    end
  end

  // Decoded from reset-cleared state so the line returns high as soon as reset asserts.
  always_comb begin
    uart_tx_o = 1'b1;
    case (r_state)
      StStart: uart_tx_o = 1'b0;
      StData:  uart_tx_o = r_shift[0];
      default: uart_tx_o = 1'b1;
    endcase
  end

`ifdef UART_TX_IRQ_EN
  logic r_irq_en, r_irq;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (w_adr == 2'd3) && wbs_sel_i[0]) r_irq_en <= wbs_dat_i[0];
      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq_o    = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign irq_o    = 1'b0;
`endif

endmodule
